serial_adder: RTL and testbench
===============================

Name: serial_adder

Overview:
- Parametrised, bit-serial successor to the combinational half/full adder cells.
- Adds two WIDTH-bit operands plus a carry-in, LSB first, using one full-adder slice, one bit per clock.
- Operands enter and results leave through valid/ready handshakes.
- Sits in the arithmetic library as the area-minimal adder for slow control-path datapaths.

Parameters:
- WIDTH, 8, operand and sum width in bits; legal range is 1 or more.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  synchronous, active-high reset.
- in_valid  input  1  operands a/b/cin are valid.
- in_ready  output  1  block can accept operands (high only in IDLE).
- a  input  WIDTH  operand A, unsigned.
- b  input  WIDTH  operand B, unsigned.
- cin  input  1  carry-in.
- out_valid  output  1  sum/carry are valid (high only in DONE).
- out_ready  input  1  consumer accepts the result.
- sum  output  WIDTH  registered sum, a+b+cin mod 2^WIDTH.
- carry  output  1  registered carry-out, bit WIDTH of a+b+cin.

Behaviour:
- Interface: one clock; reset is synchronous and active-high (ports clk, rst).
- Reset (rst high at a clk edge):
  - state goes to IDLE; out_valid=0, sum=0, carry=0.
  - Internal shift registers, carry flop and bit counter cleared.
  - in_valid/out_ready are ignored in any cycle where rst is high.
  - Reset has priority over every other event, including mid-RUN; a partial result is discarded and no out_valid is produced.
- FSM states: IDLE, RUN, DONE. in_ready=(state==IDLE); out_valid=(state==DONE), decoded from registered state.
- IDLE: on an edge with in_valid && in_ready:
  - latch a and b into shift registers; carry flop <= cin; counter <= 0.
  - sum register cleared; go to RUN.
- RUN, one bit per edge:
  - s = a_sh[0]^b_sh[0]^c; c_next = majority(a_sh[0], b_sh[0], c).
  - a_sh, b_sh shift right; sum_sh shifts right with s inserted at bit WIDTH-1; carry flop <= c_next.
  - counter increments; on the edge that processes bit WIDTH-1, go to DONE.
- Latency: out_valid rises exactly WIDTH clk edges after the accepting edge.
- DONE:
  - sum/carry hold stable while out_valid && !out_ready (unbounded backpressure).
  - On an edge with out_ready, go to IDLE; sum/carry keep their values until the next accept.
- No same-cycle accept in DONE; minimum issue interval is WIDTH+2 cycles.
- in_valid while not in IDLE: ignored, nothing latched; a, b and cin may change freely during RUN/DONE.
- WIDTH=1: RUN lasts one edge; counter must still be at least 1 bit wide.
- Counter width: $clog2(WIDTH)+1, so there is no wrap before the terminal compare.

Optional Feature:
- Macro: SERIAL_ADDER_SUB_EN.
- Defined, adds two ports:
  - input sub (1 bit): sampled with the operands on the accepting edge. When sub=1, ~b is latched instead of b and the carry flop is set to 1 (cin ignored), so sum = a-b mod 2^WIDTH and carry=1 means no borrow.
  - output overflow (1 bit): signed two's-complement overflow, equal to carry-in XOR carry-out of the MSB slice. Registered on the last RUN edge, valid with out_valid, 0 at reset.
- Undefined: no sub or overflow ports; the block is add-only, exactly as described in Behaviour.

Test Plan:
- WIDTH=8; after reset, a=0x00, b=0x00, cin=0 -> out_valid rises 8 edges after accept; sum=0x00, carry=0; in_ready low throughout RUN/DONE.
- a=0xFF, b=0x01, cin=0 -> sum=0x00, carry=1. a=0x5A, b=0x25, cin=1 -> sum=0x80, carry=0.
- Backpressure: result sum=0x80, out_ready held low 5 cycles with in_valid=1 and a/b toggling -> sum/carry/out_valid stable, no new accept. out_ready=1 -> IDLE next edge, in_ready=1.
- Reset mid-op: assert rst after the 3rd RUN edge of a=0xAA, b=0x55 -> next edge sum=0, carry=0, out_valid=0, in_ready=1. Then a=0x0F, b=0x01, cin=0 -> sum=0x10, carry=0.
- WIDTH=1 instance: a=1, b=1, cin=1 -> out_valid 1 edge after accept; sum=1, carry=1. Back-to-back ops respect the WIDTH+2 issue interval.
- SERIAL_ADDER_SUB_EN defined, WIDTH=8:
  - sub=1, a=0x10, b=0x20 -> sum=0xF0, carry=0, overflow=0.
  - sub=1, a=0x80, b=0x01 -> sum=0x7F, carry=1, overflow=1.
  - sub=0, a=0x7F, b=0x01 -> sum=0x80, overflow=1.

Source files
------------

// File: rtl/serial_adder.sv
// serial_adder: bit-serial adder. One full-adder slice adds two WIDTH-bit
// unsigned operands plus a carry-in, LSB first, one bit per clock.
// Operands are taken through an in_valid/in_ready handshake and the result
// is offered through an out_valid/out_ready handshake.
//
// Handshake rule for both ports: a transfer happens on a rising clk edge
// where valid and ready are both high; valid never waits on ready, and
// ready is a pure decode of the registered state (in_ready only in IDLE,
// out_valid only in DONE).
//
// Optional feature macro: SERIAL_ADDER_SUB_EN adds a 'sub' input (a-b via
// ~b and a forced carry-in of 1) and an 'overflow' output (signed overflow,
// carry into the MSB slice XOR carry out of it).
module serial_adder #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
`ifdef SERIAL_ADDER_SUB_EN
    input  logic             sub,
    output logic             overflow,
`endif
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             carry
);

    // One extra bit so the counter never wraps before the terminal compare,
    // and stays at least 1 bit wide when WIDTH is 1.
    localparam int CW = $clog2(WIDTH) + 1;
    localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state;
    logic [WIDTH-1:0] a_sh;
    logic [WIDTH-1:0] b_sh;
    logic [WIDTH-1:0] sum_sh;
    logic             c;
    logic [CW-1:0]    cnt;

    logic             bit_s;
    logic             bit_c;
    logic [WIDTH-1:0] sum_nxt;
    logic [WIDTH-1:0] b_load;
    logic             c_load;

    // Full-adder slice on the current LSBs and the next sum shift value.
    always_comb begin
        bit_s   = a_sh[0] ^ b_sh[0] ^ c;
        bit_c   = (a_sh[0] & b_sh[0]) | (a_sh[0] & c) | (b_sh[0] & c);
        sum_nxt = sum_sh >> 1;
        sum_nxt[WIDTH-1] = bit_s;
    end

    // Operand B and carry values captured on the accepting edge.
`ifdef SERIAL_ADDER_SUB_EN
    always_comb begin
        b_load = sub ? ~b : b;
        c_load = sub ? 1'b1 : cin;
    end
`else
    always_comb begin
        b_load = b;
        c_load = cin;
    end
`endif

    // Control FSM and datapath registers; reset discards any partial result.
    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= IDLE;
            a_sh   <= '0;
            b_sh   <= '0;
            sum_sh <= '0;
            c      <= 1'b0;
            cnt    <= '0;
`ifdef SERIAL_ADDER_SUB_EN
            overflow <= 1'b0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        a_sh   <= a;
                        b_sh   <= b_load;
                        c      <= c_load;
                        cnt    <= '0;
                        sum_sh <= '0;
                        state  <= RUN;
                    end
                end
                RUN: begin
                    a_sh   <= a_sh >> 1;
                    b_sh   <= b_sh >> 1;
                    sum_sh <= sum_nxt;
                    c      <= bit_c;
                    cnt    <= cnt + CW'(1);
                    if (cnt == LAST_BIT) begin
                        state <= DONE;
`ifdef SERIAL_ADDER_SUB_EN
                        overflow <= c ^ bit_c;
`endif
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign in_ready  = (state == IDLE);
    assign out_valid = (state == DONE);
    assign sum       = sum_sh;
    assign carry     = c;

endmodule

// File: tb/tb_serial_adder.sv
// tb_serial_adder: scoreboard bench for serial_adder. A WIDTH=8 instance
// covers add, backpressure and mid-operation reset; a WIDTH=1 instance
// covers the single-bit case and back-to-back issue spacing.
// With SERIAL_ADDER_SUB_EN defined the subtract/overflow cases also run.
module tb_serial_adder;

    logic       clk;
    logic       rst;

    logic       in_valid8, in_ready8, cin8, out_valid8, out_ready8, carry8;
    logic [7:0] a8, b8, sum8;
    logic       in_valid1, in_ready1, cin1, out_valid1, out_ready1, carry1;
    logic [0:0] a1, b1, sum1;
`ifdef SERIAL_ADDER_SUB_EN
    logic       sub8, ov8, sub1, ov1;
`endif

    logic [8:0] exp_q[$];
    logic       ov_q[$];
    logic [1:0] exp_q1[$];

    int errors = 0;
    int checks = 0;

    serial_adder #(.WIDTH(8)) u_add8 (
        .clk(clk), .rst(rst),
        .in_valid(in_valid8), .in_ready(in_ready8),
        .a(a8), .b(b8), .cin(cin8),
`ifdef SERIAL_ADDER_SUB_EN
        .sub(sub8), .overflow(ov8),
`endif
        .out_valid(out_valid8), .out_ready(out_ready8),
        .sum(sum8), .carry(carry8)
    );

    serial_adder #(.WIDTH(1)) u_add1 (
        .clk(clk), .rst(rst),
        .in_valid(in_valid1), .in_ready(in_ready1),
        .a(a1), .b(b1), .cin(cin1),
`ifdef SERIAL_ADDER_SUB_EN
        .sub(sub1), .overflow(ov1),
`endif
        .out_valid(out_valid1), .out_ready(out_ready1),
        .sum(sum1), .carry(carry1)
    );

    // Clock
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic test_reset();
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        checks++;
        if (out_valid8 !== 1'b0 || in_ready8 !== 1'b1) begin
            errors++;
            $display("FAIL reset_hs8: got out_valid=%b in_ready=%b expected 0/1", out_valid8, in_ready8);
        end
        checks++;
        if ({carry8, sum8} !== 9'h000) begin
            errors++;
            $display("FAIL reset_data8: got %h expected 000", {carry8, sum8});
        end
        checks++;
        if (out_valid1 !== 1'b0 || in_ready1 !== 1'b1 || {carry1, sum1} !== 2'b00) begin
            errors++;
            $display("FAIL reset_w1: got ov=%b ir=%b data=%b expected 0/1/00", out_valid1, in_ready1, {carry1, sum1});
        end
    endtask

    // One full transaction on the WIDTH=8 instance with latency checking.
    task automatic do_op8(input logic [7:0] aa, input logic [7:0] bb, input logic ci, input logic sb, input string name);
        logic [7:0] bm;
        logic       cm;
        logic [8:0] r;
        logic [8:0] exp_v;
        logic       ov_exp;
        logic       exp_ov;
        logic       rdy_seen;
        int         lat;
        bm = sb ? ~bb : bb;
        cm = sb ? 1'b1 : ci;
        r  = {1'b0, aa} + {1'b0, bm} + {8'd0, cm};
        ov_exp = (aa[7] == bm[7]) && (r[7] != aa[7]);
        in_valid8 = 1'b1;
        a8 = aa;
        b8 = bb;
        cin8 = ci;
`ifdef SERIAL_ADDER_SUB_EN
        sub8 = sb;
`endif
        @(posedge clk);
        exp_q.push_back(r);
        ov_q.push_back(ov_exp);
        #1;
        in_valid8 = 1'b0;
        a8 = 8'($urandom);
        b8 = 8'($urandom);
        cin8 = 1'($urandom_range(0, 1));
        lat = 0;
        rdy_seen = 1'b0;
        while (!out_valid8 && lat < 100) begin
            if (in_ready8) rdy_seen = 1'b1;
            @(posedge clk);
            #1;
            lat++;
        end
        checks++;
        if (lat !== 8) begin
            errors++;
            $display("FAIL %s_latency: got %0d edges expected 8", name, lat);
        end
        checks++;
        if (rdy_seen) begin
            errors++;
            $display("FAIL %s_in_ready_busy: got in_ready=1 during RUN expected 0", name);
        end
        exp_v  = exp_q.pop_front();
        exp_ov = ov_q.pop_front();
        checks++;
        if ({carry8, sum8} !== exp_v) begin
            errors++;
            $display("FAIL %s_result: got carry=%b sum=%h expected carry=%b sum=%h", name, carry8, sum8, exp_v[8], exp_v[7:0]);
        end
`ifdef SERIAL_ADDER_SUB_EN
        checks++;
        if (ov8 !== exp_ov) begin
            errors++;
            $display("FAIL %s_overflow: got %b expected %b", name, ov8, exp_ov);
        end
`endif
        out_ready8 = 1'b1;
        @(posedge clk);
        #1;
        out_ready8 = 1'b0;
        checks++;
        if (in_ready8 !== 1'b1 || out_valid8 !== 1'b0) begin
            errors++;
            $display("FAIL %s_release: got in_ready=%b out_valid=%b expected 1/0", name, in_ready8, out_valid8);
        end
    endtask

    task automatic test_add();
        do_op8(8'h00, 8'h00, 1'b0, 1'b0, "add_zero");
        do_op8(8'hFF, 8'h01, 1'b0, 1'b0, "add_wrap");
        do_op8(8'h5A, 8'h25, 1'b1, 1'b0, "add_cin");
        do_op8(8'hFF, 8'hFF, 1'b1, 1'b0, "add_max");
        for (int i = 0; i < 4; i++) begin
            do_op8(8'($urandom), 8'($urandom), 1'($urandom_range(0, 1)), 1'b0, "add_rand");
        end
    endtask

    task automatic test_backpressure();
        logic [8:0] held;
        int         lat;
        in_valid8 = 1'b1;
        a8 = 8'h5A;
        b8 = 8'h25;
        cin8 = 1'b1;
`ifdef SERIAL_ADDER_SUB_EN
        sub8 = 1'b0;
`endif
        @(posedge clk);
        exp_q.push_back(9'h080);
        #1;
        in_valid8 = 1'b0;
        lat = 0;
        while (!out_valid8 && lat < 100) begin
            @(posedge clk);
            #1;
            lat++;
        end
        held = exp_q.pop_front();
        checks++;
        if (out_valid8 !== 1'b1 || {carry8, sum8} !== held) begin
            errors++;
            $display("FAIL bp_first: got ov=%b data=%h expected 1/%h", out_valid8, {carry8, sum8}, held);
        end
        for (int i = 0; i < 5; i++) begin
            in_valid8 = 1'b1;
            a8 = 8'($urandom);
            b8 = 8'($urandom);
            cin8 = 1'($urandom_range(0, 1));
            out_ready8 = 1'b0;
            @(posedge clk);
            #1;
            checks++;
            if (out_valid8 !== 1'b1 || in_ready8 !== 1'b0 || {carry8, sum8} !== held) begin
                errors++;
                $display("FAIL bp_hold: got ov=%b ir=%b data=%h expected 1/0/%h", out_valid8, in_ready8, {carry8, sum8}, held);
            end
        end
        in_valid8 = 1'b0;
        out_ready8 = 1'b1;
        @(posedge clk);
        #1;
        out_ready8 = 1'b0;
        checks++;
        if (in_ready8 !== 1'b1 || out_valid8 !== 1'b0 || {carry8, sum8} !== held) begin
            errors++;
            $display("FAIL bp_release: got ir=%b ov=%b data=%h expected 1/0/%h", in_ready8, out_valid8, {carry8, sum8}, held);
        end
    endtask

    task automatic test_reset_mid();
        in_valid8 = 1'b1;
        a8 = 8'hAA;
        b8 = 8'h55;
        cin8 = 1'b0;
`ifdef SERIAL_ADDER_SUB_EN
        sub8 = 1'b0;
`endif
        @(posedge clk);
        #1;
        in_valid8 = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b1;
        out_ready8 = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        out_ready8 = 1'b0;
        checks++;
        if ({carry8, sum8} !== 9'h000 || out_valid8 !== 1'b0 || in_ready8 !== 1'b1) begin
            errors++;
            $display("FAIL reset_mid: got data=%h ov=%b ir=%b expected 000/0/1", {carry8, sum8}, out_valid8, in_ready8);
        end
        repeat (10) begin
            @(posedge clk);
            #1;
            checks++;
            if (out_valid8 !== 1'b0) begin
                errors++;
                $display("FAIL reset_mid_no_out: got out_valid=%b expected 0", out_valid8);
            end
        end
        do_op8(8'h0F, 8'h01, 1'b0, 1'b0, "after_reset");
    endtask

    task automatic test_width1();
        in_valid1 = 1'b1;
        a1 = 1'b1;
        b1 = 1'b1;
        cin1 = 1'b1;
        @(posedge clk);
        #1;
        in_valid1 = 1'b0;
        checks++;
        if (out_valid1 !== 1'b0 || in_ready1 !== 1'b0) begin
            errors++;
            $display("FAIL w1_run: got ov=%b ir=%b expected 0/0", out_valid1, in_ready1);
        end
        @(posedge clk);
        #1;
        checks++;
        if (out_valid1 !== 1'b1 || {carry1, sum1} !== 2'b11) begin
            errors++;
            $display("FAIL w1_result: got ov=%b data=%b expected 1/11", out_valid1, {carry1, sum1});
        end
        out_ready1 = 1'b1;
        @(posedge clk);
        #1;
        out_ready1 = 1'b0;
        checks++;
        if (in_ready1 !== 1'b1) begin
            errors++;
            $display("FAIL w1_release: got in_ready=%b expected 1", in_ready1);
        end
    endtask

    task automatic test_back_to_back();
        int         last_acc;
        logic [1:0] e;
        logic [1:0] r;
        last_acc = -1;
        out_ready1 = 1'b1;
        in_valid1 = 1'b1;
        for (int cyc = 0; cyc < 34; cyc++) begin
            if (cyc >= 30) in_valid1 = 1'b0;
            a1 = 1'($urandom_range(0, 1));
            b1 = 1'($urandom_range(0, 1));
            cin1 = 1'($urandom_range(0, 1));
            if (in_valid1 && in_ready1) begin
                r = 2'(a1) + 2'(b1) + 2'(cin1);
                exp_q1.push_back(r);
                if (last_acc >= 0) begin
                    checks++;
                    if (cyc - last_acc !== 3) begin
                        errors++;
                        $display("FAIL b2b_interval: got %0d cycles expected 3", cyc - last_acc);
                    end
                end
                last_acc = cyc;
            end
            if (out_valid1 && out_ready1) begin
                checks++;
                if (exp_q1.size() == 0) begin
                    errors++;
                    $display("FAIL b2b_extra: got unexpected result %b expected none", {carry1, sum1});
                end else begin
                    e = exp_q1.pop_front();
                    if ({carry1, sum1} !== e) begin
                        errors++;
                        $display("FAIL b2b_result: got %b expected %b", {carry1, sum1}, e);
                    end
                end
            end
            @(posedge clk);
            #1;
        end
        out_ready1 = 1'b0;
        checks++;
        if (exp_q1.size() != 0 || last_acc < 0) begin
            errors++;
            $display("FAIL b2b_drain: got %0d pending expected 0", exp_q1.size());
        end
    endtask

`ifdef SERIAL_ADDER_SUB_EN
    task automatic test_sub();
        do_op8(8'h10, 8'h20, 1'b0, 1'b1, "sub_neg");
        do_op8(8'h80, 8'h01, 1'b1, 1'b1, "sub_ovf");
        do_op8(8'h7F, 8'h01, 1'b0, 1'b0, "add_ovf");
        for (int i = 0; i < 3; i++) begin
            do_op8(8'($urandom), 8'($urandom), 1'($urandom_range(0, 1)), 1'b1, "sub_rand");
        end
    endtask
`endif

    initial begin
        rst = 1'b1;
        in_valid8 = 1'b0; out_ready8 = 1'b0; a8 = '0; b8 = '0; cin8 = 1'b0;
        in_valid1 = 1'b0; out_ready1 = 1'b0; a1 = '0; b1 = '0; cin1 = 1'b0;
`ifdef SERIAL_ADDER_SUB_EN
        sub8 = 1'b0;
        sub1 = 1'b0;
`endif
        test_reset();
        test_add();
        test_backpressure();
        test_reset_mid();
        test_width1();
        test_back_to_back();
`ifdef SERIAL_ADDER_SUB_EN
        test_sub();
`endif
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
